// File: rtl/mc_control_pkg.sv
// Shared control definitions for the multi-cycle MIPS controller and its datapath:
// state codes, opcodes, ALUOp / ALUSrcB / PCSource encodings and the control word.
package mc_control_pkg;

    // State codes are visible on the debug port, so the numeric values are fixed.
    typedef enum logic [3:0] {
        ST_FETCH  = 4'd0,
        ST_DECODE = 4'd1,
        ST_MEMADR = 4'd2,
        ST_MEMRD  = 4'd3,
        ST_MEMWB  = 4'd4,
        ST_MEMWR  = 4'd5,
        ST_EXEC   = 4'd6,
        ST_RWB    = 4'd7,
        ST_BEQ    = 4'd8,
        ST_JUMP   = 4'd9,
        ST_ADDIX  = 4'd10,
        ST_ADDIWB = 4'd11
    } state_t;

    // Instruction opcodes, IR[31:26]
    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_ADDI  = 6'b001000;

    // ALU operation select
    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_SUB   = 2'b01;
    localparam logic [1:0] ALUOP_FUNCT = 2'b10;

    // ALU B-operand select
    localparam logic [1:0] SRCB_REGB    = 2'b00;
    localparam logic [1:0] SRCB_FOUR    = 2'b01;
    localparam logic [1:0] SRCB_IMM     = 2'b10;
    localparam logic [1:0] SRCB_IMM_SH2 = 2'b11;

    // Next-PC source select
    localparam logic [1:0] PCSRC_ALU    = 2'b00;
    localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
    localparam logic [1:0] PCSRC_JUMP   = 2'b10;

    // One bundle per cycle for every datapath strobe and select
    typedef struct packed {
        logic       pc_write;
        logic       pc_write_cond;
        logic       iord;
        logic       mem_read;
        logic       mem_write;
        logic       ir_write;
        logic       mem_to_reg;
        logic       reg_dst;
        logic       reg_write;
        logic [1:0] pc_source;
        logic [1:0] alu_op;
        logic       alu_src_a;
        logic [1:0] alu_src_b;
    } ctrl_t;

endpackage

// File: rtl/mc_ctrl_outdec.sv
// Moore output decoder: current state -> datapath control word.
// The only input dependence is mem_ready in FETCH, which qualifies the IR/PC load
// so the instruction is captured exactly on the cycle memory delivers it.
// Build option MC_ADDI_EN: adds the control words for the addi states 10/11.
module mc_ctrl_outdec
    import mc_control_pkg::*;
(
    input  state_t i_state,
    input  logic   i_mem_ready,
    output ctrl_t  o_ctrl
);

    // Decode one control word per state; anything not listed stays 0
    always_comb begin
        o_ctrl = '0;
        case (i_state)
            ST_FETCH: begin
                o_ctrl.mem_read  = 1'b1;
                o_ctrl.alu_src_a = 1'b0;
                o_ctrl.alu_src_b = SRCB_FOUR;
                o_ctrl.alu_op    = ALUOP_ADD;
                o_ctrl.pc_source = PCSRC_ALU;
                o_ctrl.ir_write  = i_mem_ready;
                o_ctrl.pc_write  = i_mem_ready;
            end
            ST_DECODE: begin
                o_ctrl.alu_src_a = 1'b0;
                o_ctrl.alu_src_b = SRCB_IMM_SH2;
                o_ctrl.alu_op    = ALUOP_ADD;
            end
            ST_MEMADR: begin
                o_ctrl.alu_src_a = 1'b1;
                o_ctrl.alu_src_b = SRCB_IMM;
                o_ctrl.alu_op    = ALUOP_ADD;
            end
            ST_MEMRD: begin
                o_ctrl.mem_read = 1'b1;
                o_ctrl.iord     = 1'b1;
            end
            ST_MEMWB: begin
                o_ctrl.reg_write  = 1'b1;
                o_ctrl.mem_to_reg = 1'b1;
                o_ctrl.reg_dst    = 1'b0;
            end
            ST_MEMWR: begin
                o_ctrl.mem_write = 1'b1;
                o_ctrl.iord      = 1'b1;
            end
            ST_EXEC: begin
                o_ctrl.alu_src_a = 1'b1;
                o_ctrl.alu_src_b = SRCB_REGB;
                o_ctrl.alu_op    = ALUOP_FUNCT;
            end
            ST_RWB: begin
                o_ctrl.reg_write  = 1'b1;
                o_ctrl.reg_dst    = 1'b1;
                o_ctrl.mem_to_reg = 1'b0;
            end
            ST_BEQ: begin
                o_ctrl.alu_src_a     = 1'b1;
                o_ctrl.alu_src_b     = SRCB_REGB;
                o_ctrl.alu_op        = ALUOP_SUB;
                o_ctrl.pc_write_cond = 1'b1;
                o_ctrl.pc_source     = PCSRC_ALUOUT;
            end
            ST_JUMP: begin
                o_ctrl.pc_write  = 1'b1;
                o_ctrl.pc_source = PCSRC_JUMP;
            end
`ifdef MC_ADDI_EN
            ST_ADDIX: begin
                o_ctrl.alu_src_a = 1'b1;
                o_ctrl.alu_src_b = SRCB_IMM;
                o_ctrl.alu_op    = ALUOP_ADD;
            end
            ST_ADDIWB: begin
                o_ctrl.reg_write  = 1'b1;
                o_ctrl.reg_dst    = 1'b0;
                o_ctrl.mem_to_reg = 1'b0;
            end
`endif
            default: o_ctrl = '0;
        endcase
    end

endmodule

// File: rtl/mc_control.sv
// Multi-cycle MIPS control FSM (Moore). Sequences one instruction at a time,
// counts retired instructions and flags undecodable opcodes (sticky until rst).
// Build option MC_ADDI_EN: addi decodes to ADDIX/ADDIWB; without it addi is illegal.
//
// Memory handshake: mem_ready is a one-cycle "done" from memory. FETCH, MEMRD and
// MEMWR hold their request strobes and stay put until mem_ready is seen high at a
// clock edge; everywhere else mem_ready has no effect.
module mc_control
    import mc_control_pkg::*;
#(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [5:0]       opcode,
    input  logic             mem_ready,
    output logic             PCWrite,
    output logic             PCWriteCond,
    output logic             IorD,
    output logic             MemRead,
    output logic             MemWrite,
    output logic             IRWrite,
    output logic             MemtoReg,
    output logic             RegDst,
    output logic             RegWrite,
    output logic [1:0]       PCSource,
    output logic [1:0]       ALUOp,
    output logic             ALUSrcA,
    output logic [1:0]       ALUSrcB,
    output logic [3:0]       state,
    output logic             illegal_op,
    output logic [CNT_W-1:0] instr_count
);

    state_t           r_state;
    logic [CNT_W-1:0] r_instr_count;
    logic             r_illegal_op;
    ctrl_t            w_ctrl;
    ctrl_t            w_ctrl_gated;

    mc_ctrl_outdec u_outdec (
        .i_state     (r_state),
        .i_mem_ready (mem_ready),
        .o_ctrl      (w_ctrl)
    );

    // Next-state sequencing, retired-instruction count and sticky illegal flag
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state       <= ST_FETCH;
            r_instr_count <= '0;
            r_illegal_op  <= 1'b0;
        end else begin
            case (r_state)
                ST_FETCH: begin
                    if (mem_ready) r_state <= ST_DECODE;
                end
                ST_DECODE: begin
                    case (opcode)
                        OP_RTYPE:     r_state <= ST_EXEC;
                        OP_LW, OP_SW: r_state <= ST_MEMADR;
                        OP_BEQ:       r_state <= ST_BEQ;
                        OP_J:         r_state <= ST_JUMP;
`ifdef MC_ADDI_EN
                        OP_ADDI:      r_state <= ST_ADDIX;
`endif
                        default: begin
                            r_state      <= ST_FETCH;
                            r_illegal_op <= 1'b1;
                        end
                    endcase
                end
                ST_MEMADR: begin
                    // Opcode was validated in DECODE; the fallback only guards a corrupted IR
                    if (opcode == OP_LW)      r_state <= ST_MEMRD;
                    else if (opcode == OP_SW) r_state <= ST_MEMWR;
                    else                      r_state <= ST_FETCH;
                end
                ST_MEMRD: begin
                    if (mem_ready) r_state <= ST_MEMWB;
                end
                ST_MEMWR: begin
                    if (mem_ready) begin
                        r_state       <= ST_FETCH;
                        r_instr_count <= r_instr_count + CNT_W'(1);
                    end
                end
                ST_EXEC: r_state <= ST_RWB;
                ST_MEMWB, ST_RWB, ST_BEQ, ST_JUMP: begin
                    r_state       <= ST_FETCH;
                    r_instr_count <= r_instr_count + CNT_W'(1);
                end
`ifdef MC_ADDI_EN
                ST_ADDIX: r_state <= ST_ADDIWB;
                ST_ADDIWB: begin
                    r_state       <= ST_FETCH;
                    r_instr_count <= r_instr_count + CNT_W'(1);
                end
`endif
                default: r_state <= ST_FETCH;
            endcase
        end
    end

    // Reset aborts the instruction in the same cycle: no strobe or select may escape
    always_comb begin
        w_ctrl_gated = w_ctrl;
        if (rst) w_ctrl_gated = '0;
    end

    assign PCWrite     = w_ctrl_gated.pc_write;
    assign PCWriteCond = w_ctrl_gated.pc_write_cond;
    assign IorD        = w_ctrl_gated.iord;
    assign MemRead     = w_ctrl_gated.mem_read;
    assign MemWrite    = w_ctrl_gated.mem_write;
    assign IRWrite     = w_ctrl_gated.ir_write;
    assign MemtoReg    = w_ctrl_gated.mem_to_reg;
    assign RegDst      = w_ctrl_gated.reg_dst;
    assign RegWrite    = w_ctrl_gated.reg_write;
    assign PCSource    = w_ctrl_gated.pc_source;
    assign ALUOp       = w_ctrl_gated.alu_op;
    assign ALUSrcA     = w_ctrl_gated.alu_src_a;
    assign ALUSrcB     = w_ctrl_gated.alu_src_b;
    assign state       = r_state;
    assign illegal_op  = r_illegal_op;
    assign instr_count = r_instr_count;

endmodule
